// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Shares one UART transmit path (TX FIFO + serializer) among
//             NUM_REQ byte-stream requesters. Grants one requester at a time
//             in round-robin order, optionally prepends a requester-ID header
//             byte, loads the FIFO in bursts of at most MAX_BURST bytes,
//             pulses the transmit start and waits for each burst to drain.
//  Ports    :
//    pi_clk            clock
//    pi_rst            asynchronous active-low reset
//    pi_valid[N]       per-requester byte valid
//    pi_data[N*W]      per-requester byte, requester i at [i*W +: W]
//    pi_last[N]        final byte of the requester's frame
//    po_ready[N]       byte accepted when pi_valid[i] && po_ready[i]
//    po_grant[N]       one-hot current owner
//    po_busy           high whenever the scheduler is not idle
//    po_t_data[W]      byte written to the TX FIFO
//    po_fifo_write_en  TX FIFO write strobe, one cycle per byte
//    pi_fifo_full      TX FIFO full
//    po_start_tran     one-cycle transmit start pulse
//    pi_tran_over      TX FIFO empty and serializer idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = 5,
    parameter int ID_HEADER  = 1
) (
    input  logic                          pi_clk,
    input  logic                          pi_rst,
    input  logic [NUM_REQ-1:0]            pi_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] pi_data,
    input  logic [NUM_REQ-1:0]            pi_last,
    output logic [NUM_REQ-1:0]            po_ready,
    output logic [NUM_REQ-1:0]            po_grant,
    output logic                          po_busy,
    output logic [DATA_WIDTH-1:0]         po_t_data,
    output logic                          po_fifo_write_en,
    input  logic                          pi_fifo_full,
    output logic                          po_start_tran,
    input  logic                          pi_tran_over
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_jw    = c_idx_w + 1;
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);

    localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_BURST);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_jw-1:0]    c_num_req  = c_jw'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_gidx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_last_seen;
    logic                 r_wait_first;

    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
    logic                  w_sel_found;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic [c_jw-1:0]       w_j;
    logic                  w_hs;
    logic                  w_last;
    logic [c_cnt_w-1:0]    w_cnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = pi_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: first requester with valid set, scanning upward
    // from the pointer and wrapping at NUM_REQ.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = {1'b0, r_ptr} + c_jw'(k);
            if (w_j >= c_num_req) begin
                w_j = w_j - c_num_req;
            end
            if (!w_sel_found && pi_valid[w_j[c_idx_w-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_j[c_idx_w-1:0];
            end
        end
    end

    // Ready only toward the granted requester, and only while the FIFO can
    // take a byte and the burst still has room.
    always_comb begin
        po_ready = '0;
        if (r_state == S_LOAD && !pi_fifo_full && r_cnt < c_max_cnt) begin
            po_ready = po_grant;
        end
    end

    assign w_hs      = |(pi_valid & po_ready);
    assign w_last    = pi_last[r_gidx];
    assign w_cnt_inc = r_cnt + c_cnt_w'(1);

    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            r_state          <= S_IDLE;
            r_ptr            <= '0;
            r_gidx           <= '0;
            r_cnt            <= '0;
            r_last_seen      <= 1'b0;
            r_wait_first     <= 1'b0;
            po_grant         <= '0;
            po_busy          <= 1'b0;
            po_t_data        <= '0;
            po_fifo_write_en <= 1'b0;
            po_start_tran    <= 1'b0;
        end else begin
            po_fifo_write_en <= 1'b0;
            po_start_tran    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        po_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
                        r_gidx      <= w_sel_idx;
                        po_busy     <= 1'b1;
                        r_cnt       <= '0;
                        r_last_seen <= 1'b0;
                        r_state     <= (ID_HEADER != 0) ? S_HDR : S_LOAD;
                    end
                end
                S_HDR: begin
                    if (!pi_fifo_full) begin
                        po_fifo_write_en <= 1'b1;
                        po_t_data        <= DATA_WIDTH'(r_gidx);
                        r_cnt            <= c_cnt_w'(1);
                        r_state          <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        po_fifo_write_en <= 1'b1;
                        po_t_data        <= w_req_data[r_gidx];
                        r_cnt            <= w_cnt_inc;
                        if (w_last) begin
                            r_last_seen <= 1'b1;
                        end
                        if (w_cnt_inc == c_max_cnt || w_last) begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    // The last write strobe is on the bus this cycle, so the
                    // start pulse lands strictly after it.
                    po_start_tran <= 1'b1;
                    r_wait_first  <= 1'b1;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    // UART status lags the start pulse by a cycle; a stale
                    // tran_over seen right away must not end the wait.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (pi_tran_over) begin
                        r_cnt <= '0;
                        if (r_last_seen) begin
                            r_last_seen <= 1'b0;
                            r_ptr       <= (r_gidx == c_last_idx) ? '0
                                                                  : r_gidx + c_idx_w'(1);
                            po_grant    <= '0;
                            po_busy     <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the UART transmit path (TX FIFO plus serializer) between NUM_REQ byte-stream requesters.
- Grants one requester at a time, round-robin. Optionally prepends a requester-ID header byte.
- Loads the TX FIFO in bursts of at most MAX_BURST bytes and triggers each transmission.
- Waits for each burst to drain before loading the next. Sits between the requester logic and the UART top-level transmit interface.

Parameters:
- DATA_WIDTH, 8, byte width; must match the UART data width.
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BURST, 5, bytes written per transmission; equals the TX FIFO depth.
- ID_HEADER, 1, 1 = write a header byte (requester index, zero-extended) before each frame.

Ports:
- pi_clk  in  1  clock.
- pi_rst  in  1  asynchronous active-low reset.
- pi_valid  in  NUM_REQ  per-requester byte valid.
- pi_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- pi_last  in  NUM_REQ  marks the final byte of a requester's frame.
- po_ready  out  NUM_REQ  byte accepted when pi_valid[i] && po_ready[i].
- po_grant  out  NUM_REQ  one-hot current owner.
- po_busy  out  1  high in any state other than IDLE.
- po_t_data  out  DATA_WIDTH  byte to TX FIFO.
- po_fifo_write_en  out  1  TX FIFO write strobe, one cycle per byte.
- pi_fifo_full  in  1  TX FIFO full.
- po_start_tran  out  1  one-cycle transmit start pulse.
- pi_tran_over  in  1  high when the TX FIFO is empty and the serializer is idle.

Behaviour:
- Reset (pi_rst=0, asynchronous):
  - State = IDLE.
  - All outputs = 0.
  - Round-robin pointer = 0.
  - Burst counter = 0; last-seen flag = 0.
  - Reset mid-frame aborts the frame with no further writes. The TX FIFO is not flushed by this block.
- Registered outputs: po_fifo_write_en, po_t_data, po_start_tran, po_grant, po_busy.
- po_ready is combinational from state, grant, pi_fifo_full and the burst counter.
- FSM IDLE:
  - If any pi_valid is set, choose the first set bit at or after the pointer (modulo NUM_REQ).
  - Register po_grant, then go to HDR if ID_HEADER=1, else LOAD.
  - Pointer is not updated here.
- FSM HDR:
  - When !pi_fifo_full: po_fifo_write_en=1, po_t_data = grant index, counter=1, go to LOAD.
  - Otherwise stall.
- FSM LOAD:
  - po_ready[g] = !pi_fifo_full && counter < MAX_BURST; all other ready bits are 0.
  - On handshake: next cycle po_fifo_write_en=1 and po_t_data = requester byte; counter increments.
  - If pi_last was set on the accepted byte, set the last-seen flag.
  - Exit to START when the counter reaches MAX_BURST or a last byte is accepted.
  - A requester dropping valid simply stalls LOAD. There is no timeout.
- FSM START:
  - One cycle, entered after the final write strobe has been issued; po_start_tran=1.
  - Go to WAIT.
- FSM WAIT:
  - Ignore pi_tran_over in the first WAIT cycle, because the UART status lags the start pulse.
  - Afterwards, on pi_tran_over=1: counter=0.
  - If the last-seen flag is set: clear it, set pointer = (g+1) mod NUM_REQ, clear grant, go to IDLE.
  - Otherwise go to LOAD (the frame continues under the same grant; no new header).
- Header counts toward MAX_BURST, so a 4-byte frame with ID_HEADER=1 and MAX_BURST=5 fits one burst.
- Never write while pi_fifo_full=1; the write strobe is qualified by full in the same cycle the decision is made.
- A frame longer than MAX_BURST is split into several bursts. Grant is held across bursts; no interleaving between requesters.
- Counter width is clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- A single-byte frame with ID_HEADER=0 gives exactly one write, one start, then IDLE.

Test Plan:
- Req0 sends 3 bytes 11,22,33 (last on 33), ID_HEADER=1 -> FIFO writes 00,11,22,33 in order, one po_start_tran, po_busy drops after pi_tran_over; pointer moves to 1.
- Req0 and Req1 valid together from reset -> Req0 frame served first, then Req1 (header 01). Then Req0 again -> served only after Req1 (round-robin verified).
- Req1 sends a 9-byte frame, MAX_BURST=5, ID_HEADER=1 -> bursts of 5 (header + 4 bytes), then 5 bytes. Two start pulses, each after pi_tran_over; grant held throughout.
- pi_fifo_full forced high for 4 cycles mid-LOAD -> po_ready and po_fifo_write_en stay 0; no byte lost or duplicated after release.
- pi_tran_over held high constantly -> first WAIT cycle ignored; next burst does not begin before the WAIT state has lasted at least 2 cycles.
- pi_rst asserted in LOAD after 2 bytes -> all outputs 0 immediately. After release, a fresh request from Req1 starts with header 01 and counter 1.
